mem_arbiter: RTL and testbench

Two-port arbiter that shares the single external memory interface (32-bit address, 256-bit line, cs/we/ack handshake) between the instruction-side requester (port 0) and the data-side L1 cache (port 1). It sits between the CPU's cache refill/writeback paths and the external memory pins. Each transaction is serialized and granted by a round-robin policy. Responses are returned to the owning port only.

---
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port round-robin arbiter sharing one external line-wide
//                memory interface (cs/we/ack handshake) between the
//                instruction-side requester (port 0) and the data-side L1
//                cache (port 1). One transaction at a time; responses are
//                steered back to the owning port only. All outputs are
//                registered, so no input reaches an output combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_cs,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [LINE_W-1:0] p0_data_i,
  output logic [LINE_W-1:0] p0_data_o,
  output logic              p0_ack,

  input  logic              p1_cs,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [LINE_W-1:0] p1_data_i,
  output logic [LINE_W-1:0] p1_data_o,
  output logic              p1_ack,

  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack,

  output logic              busy
);

  // Transaction phases: waiting for a request, external access in flight,
  // and a one-cycle turnaround while the requester drops its cs.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              prio_q, prio_d;      // port that wins a tie
  logic              owner_q, owner_d;    // port that owns the current access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              mem_cs_q, mem_cs_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic [LINE_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [LINE_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              busy_q, busy_d;

  logic              req_any;
  logic              grant_owner;

  // Arbitration: a lone requester wins outright, a tie goes to the priority port.
  always_comb begin
    req_any = p0_cs | p1_cs;
    if (p0_cs && p1_cs) begin
      grant_owner = prio_q;
    end else begin
      grant_owner = p1_cs;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; mem_ack only matters while an access is in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_any) state_d = S_ACCESS;
      S_ACCESS: if (mem_ack) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and request-register next values. Requester inputs are latched
  // only at grant, so changes during the access never reach the memory pins.
  always_comb begin
    prio_d     = prio_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_cs_d   = mem_cs_q;
    p0_ack_d   = 1'b0;
    p1_ack_d   = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          owner_d  = grant_owner;
          we_d     = grant_owner ? p1_we     : p0_we;
          addr_d   = grant_owner ? p1_addr   : p0_addr;
          wdata_d  = grant_owner ? p1_data_i : p0_data_i;
          mem_cs_d = 1'b1;
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          mem_cs_d = 1'b0;
          prio_d   = ~owner_q;
          if (owner_q) begin
            p1_ack_d = 1'b1;
            if (!we_q) p1_rdata_d = mem_data_i;
          end else begin
            p0_ack_d = 1'b1;
            if (!we_q) p0_rdata_d = mem_data_i;
          end
        end
      end
      default: begin
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Registered outputs and request registers; reset abandons any access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_q     <= 1'b1;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_cs_q   <= 1'b0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_cs_q   <= mem_cs_d;
      p0_ack_q   <= p0_ack_d;
      p1_ack_q   <= p1_ack_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_cs     = mem_cs_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_data_o = wdata_q;
  assign p0_ack     = p0_ack_q;
  assign p1_ack     = p1_ack_q;
  assign p0_data_o  = p0_rdata_q;
  assign p1_data_o  = p1_rdata_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter. Requester tasks push each
//                request into a per-port queue; a monitor predicts grants
//                from the round-robin rule and checks memory-side fields,
//                ack timing/steering and read data against a memory table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] data;
  } req_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         p0_cs = 1'b0, p0_we = 1'b0, p1_cs = 1'b0, p1_we = 1'b0;
  logic [31:0]  p0_addr = '0, p1_addr = '0;
  logic [255:0] p0_data_i = '0, p1_data_i = '0;
  logic [255:0] p0_data_o, p1_data_o;
  logic         p0_ack, p1_ack;
  logic         mem_cs, mem_we, busy;
  logic [31:0]  mem_addr;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack = 1'b0;

  mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk(clk), .rst(rst),
    .p0_cs(p0_cs), .p0_we(p0_we), .p0_addr(p0_addr), .p0_data_i(p0_data_i),
    .p0_data_o(p0_data_o), .p0_ack(p0_ack),
    .p1_cs(p1_cs), .p1_we(p1_we), .p1_addr(p1_addr), .p1_data_i(p1_data_i),
    .p1_data_o(p1_data_o), .p1_ack(p1_ack),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack(mem_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void chkb(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endfunction

  function automatic void chki(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Memory contents seen by reads (writes do not alter this table).
  function automatic logic [255:0] rdfun(input logic [31:0] a);
    if (a == 32'h100) return {32{8'hA5}};
    return {a, ~a, a ^ 32'h5A5A5A5A, a + 32'd1, a * 32'd3, {a[15:0], a[31:16]},
            a ^ 32'hFFFF0000, 32'hC0FFEE00 ^ a};
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scoreboard state ----------------
  req_t         q0[$];
  req_t         q1[$];
  logic [255:0] last_rd [2];
  logic         last_owner = 1'b0;   // reset state makes port 1 win the first tie
  logic         cur_owner = 1'b0;
  int           ack_cnt [2];
  int           grant_cnt [2];
  int           n_grants = 0;
  int           cyc = 0;
  int           fall_cyc = 0;
  bit           fall_valid = 1'b0;
  int           own_log[$];
  int           gap_log[$];

  // Values as seen by the DUT at the most recent rising edge.
  logic cs0_e = 1'b0, cs1_e = 1'b0, mem_cs_e = 1'b0, mem_ack_e = 1'b0, busy_e = 1'b0, rst_e = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      cs0_e     <= p0_cs;
      cs1_e     <= p1_cs;
      mem_cs_e  <= mem_cs;
      mem_ack_e <= mem_ack;
      busy_e    <= busy;
      rst_e     <= rst;
    end
  end

  // ---------------- memory responder ----------------
  bit           resp_en = 1'b1;
  bit           force_ack = 1'b0;
  int           fixed_lat = -1;
  bit           r_act = 1'b0;
  int           r_cnt = 0;
  logic         r_we;
  logic [31:0]  r_addr;
  logic [255:0] r_d;

  initial begin
    forever begin
      @(negedge clk);
      mem_ack    = force_ack;
      mem_data_i = rand256();
      if (resp_en && mem_cs) begin
        if (!r_act) begin
          r_act  = 1'b1;
          r_cnt  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
          r_we   = mem_we;
          r_addr = mem_addr;
          r_d    = mem_data_o;
        end else begin
          chkb("mem_we_stable", mem_we, r_we);
          chk("mem_addr_stable", {224'd0, mem_addr}, {224'd0, r_addr});
          chk("mem_data_stable", mem_data_o, r_d);
        end
        if (r_cnt == 0) begin
          mem_ack    = 1'b1;
          mem_data_i = rdfun(r_addr);
        end else begin
          r_cnt--;
        end
      end else begin
        r_act = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic m_own;
  int   m_port;
  req_t m_r;
  bit   m_have;
  logic exp_ack, exp_grant, rose;

  initial begin
    last_rd[0] = '0; last_rd[1] = '0;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    grant_cnt[0] = 0; grant_cnt[1] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_e) begin
        chkb("rst_mem_cs", mem_cs, 1'b0);
        chkb("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", {224'd0, mem_addr}, 256'd0);
        chk("rst_mem_data_o", mem_data_o, 256'd0);
        chkb("rst_p0_ack", p0_ack, 1'b0);
        chkb("rst_p1_ack", p1_ack, 1'b0);
        chk("rst_p0_data_o", p0_data_o, 256'd0);
        chk("rst_p1_data_o", p1_data_o, 256'd0);
        chkb("rst_busy", busy, 1'b0);
        q0.delete(); q1.delete();
        last_rd[0] = '0; last_rd[1] = '0;
        last_owner = 1'b0;
        fall_valid = 1'b0;
      end else begin
        // completion side
        exp_ack = mem_ack_e && mem_cs_e;
        chkb("ack_pulse", p0_ack | p1_ack, exp_ack);
        chkb("ack_exclusive", p0_ack & p1_ack, 1'b0);
        chkb("mem_cs_drop", !mem_cs && mem_cs_e, exp_ack);
        if (p0_ack || p1_ack) begin
          m_port = p1_ack ? 1 : 0;
          chki("ack_owner", m_port, int'(cur_owner));
          ack_cnt[m_port]++;
          m_have = 1'b0;
          if (m_port == 0 && q0.size() > 0) begin m_r = q0.pop_front(); m_have = 1'b1; end
          if (m_port == 1 && q1.size() > 0) begin m_r = q1.pop_front(); m_have = 1'b1; end
          chkb("ack_has_request", m_have, 1'b1);
          if (m_have && !m_r.we) last_rd[m_port] = rdfun(m_r.addr);
        end
        chk("p0_data_o", p0_data_o, last_rd[0]);
        chk("p1_data_o", p1_data_o, last_rd[1]);
        chkb("busy", busy, mem_cs | p0_ack | p1_ack);
        if (!mem_cs && mem_cs_e) begin
          fall_cyc   = cyc;
          fall_valid = 1'b1;
        end
        // grant side: idle arbiter must grant any pending request
        exp_grant = !busy_e && (cs0_e || cs1_e);
        rose      = mem_cs && !mem_cs_e;
        chkb("grant_event", rose, exp_grant);
        if (rose) begin
          n_grants++;
          m_own      = (cs0_e && cs1_e) ? ~last_owner : cs1_e;
          last_owner = m_own;
          cur_owner  = m_own;
          grant_cnt[m_own]++;
          own_log.push_back(int'(m_own));
          if (fall_valid) gap_log.push_back(cyc - fall_cyc);
          m_have = 1'b0;
          if (!m_own && q0.size() > 0) begin m_r = q0[0]; m_have = 1'b1; end
          if (m_own && q1.size() > 0) begin m_r = q1[0]; m_have = 1'b1; end
          chkb("grant_has_request", m_have, 1'b1);
          if (m_have) begin
            chkb("grant_mem_we", mem_we, m_r.we);
            chk("grant_mem_addr", {224'd0, mem_addr}, {224'd0, m_r.addr});
            chk("grant_mem_data_o", mem_data_o, m_r.data);
          end
        end
      end
    end
  end

  // ---------------- requester tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic cs, input logic we, input logic [31:0] a,
                          input logic [255:0] d);
    if (p == 0) begin
      p0_cs = cs; p0_we = we; p0_addr = a; p0_data_i = d;
    end else begin
      p1_cs = cs; p1_we = we; p1_addr = a; p1_data_i = d;
    end
  endtask

  task automatic wait_ack(input int p);
    bit got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      tick();
      if ((p == 0) ? p0_ack : p1_ack) got = 1'b1;
    end
    if (!got) chkb("ack_timeout", 1'b0, 1'b1);
  endtask

  // Issue one request, optionally scramble inputs once granted, hold cs
  // for 'hold' extra cycles after ack, then drop it.
  task automatic drive(input int p, input logic we, input logic [31:0] a, input logic [255:0] d,
                       input bit scr, input int hold);
    req_t r;
    int   g0;
    bit   got = 1'b0;
    r.we = we; r.addr = a; r.data = d;
    tick();
    g0 = grant_cnt[p];
    set_port(p, 1'b1, we, a, d);
    if (p == 0) q0.push_back(r); else q1.push_back(r);
    for (int n = 0; n < 300 && !got; n++) begin
      tick();
      if ((p == 0) ? p0_ack : p1_ack) got = 1'b1;
      else if (scr && grant_cnt[p] != g0)
        set_port(p, 1'b1, 1'($urandom_range(0, 1)), $urandom, rand256());
    end
    if (!got) chkb("ack_timeout", 1'b0, 1'b1);
    for (int h = 0; h < hold; h++) tick();
    set_port(p, 1'b0, 1'b0, 32'd0, 256'd0);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] saved;
    req_t         r;
    int           g0, a0, w;

    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;

    // Port 1 read of 0x100 with a 3-cycle memory latency.
    fixed_lat = 3;
    drive(1, 1'b0, 32'h100, rand256(), 1'b0, 0);
    fixed_lat = -1;
    chk("t1_p1_data", p1_data_o, {32{8'hA5}});
    chki("t1_p0_acks", ack_cnt[0], 0);
    chki("t1_p1_acks", ack_cnt[1], 1);

    // Port 0 write with inputs scrambled during the access.
    saved = p0_data_o;
    drive(0, 1'b1, 32'h40, {16{16'h1234}}, 1'b1, 0);
    chk("t3_p0_data_unchanged", p0_data_o, saved);

    // Spurious mem_ack while idle.
    repeat (2) tick();
    a0 = ack_cnt[0] + ack_cnt[1];
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    repeat (3) tick();
    chkb("t4_busy", busy, 1'b0);
    chkb("t4_mem_cs", mem_cs, 1'b0);
    chki("t4_acks", ack_cnt[0] + ack_cnt[1], a0);

    // Port 1 slow to drop cs: held through DONE only -> no extra grant.
    g0 = n_grants;
    drive(1, 1'b0, 32'h200, rand256(), 1'b0, 1);
    repeat (4) tick();
    chki("t6_single_grant", n_grants - g0, 1);

    // Port 1 holds cs into IDLE -> exactly one extra transaction.
    g0 = n_grants; a0 = ack_cnt[1];
    r.we = 1'b0; r.addr = 32'h280; r.data = rand256();
    tick();
    set_port(1, 1'b1, r.we, r.addr, r.data);
    q1.push_back(r);
    wait_ack(1);
    q1.push_back(r);
    tick();
    wait_ack(1);
    set_port(1, 1'b0, 1'b0, 32'd0, 256'd0);
    repeat (4) tick();
    chki("t6_regrant_grants", n_grants - g0, 2);
    chki("t6_regrant_acks", ack_cnt[1] - a0, 2);

    // Simultaneous requests after reset, three back-to-back each.
    do_reset();
    repeat (2) tick();
    own_log.delete();
    gap_log.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) drive(0, 1'b0, 32'h1000 + 32'(i * 32), rand256(), 1'b0, 0);
      end
      begin
        for (int i = 0; i < 3; i++) drive(1, 1'b1, 32'h2000 + 32'(i * 32), rand256(), 1'b0, 0);
      end
    join
    chki("t2_grant_count", own_log.size(), 6);
    for (int i = 0; i < own_log.size() && i < 6; i++)
      chki("t2_grant_order", own_log[i], (i % 2 == 0) ? 1 : 0);
    chki("t2_gap_count", gap_log.size(), 5);
    for (int i = 0; i < gap_log.size(); i++) chki("t2_gap_len", gap_log[i], 2);

    // Randomized traffic from both ports.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          w = $urandom_range(0, 3);
          repeat (w) tick();
          drive(0, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFE0, rand256(),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          drive(1, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFE0, rand256(),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end
      end
    join
    repeat (4) tick();

    // Reset asserted in the middle of an access.
    resp_en = 1'b0;
    r.we = 1'b0; r.addr = 32'h300; r.data = rand256();
    set_port(0, 1'b1, r.we, r.addr, r.data);
    q0.push_back(r);
    for (int n = 0; n < 20 && !mem_cs; n++) tick();
    chkb("t5_access_started", mem_cs, 1'b1);
    repeat (2) tick();
    rst = 1'b0;
    set_port(0, 1'b0, 1'b0, 32'd0, 256'd0);
    tick();
    chkb("t5_mem_cs", mem_cs, 1'b0);
    chkb("t5_busy", busy, 1'b0);
    chk("t5_p0_data", p0_data_o, 256'd0);
    chk("t5_p1_data", p1_data_o, 256'd0);
    chk("t5_mem_data_o", mem_data_o, 256'd0);
    rst = 1'b1;
    resp_en = 1'b1;
    own_log.delete();
    fork
      drive(0, 1'b0, 32'h400, rand256(), 1'b0, 0);
      drive(1, 1'b0, 32'h500, rand256(), 1'b0, 0);
    join
    chki("t5_tie_count", own_log.size(), 2);
    if (own_log.size() > 0) chki("t5_tie_winner", own_log[0], 1);

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
